// File: rtl/fft_r2_stage_if.sv
// Frame-wide bus for one radix-2 FFT stage: a complex frame in, a complex frame out,
// plus the sticky saturation flag and its clear.
interface fft_r2_stage_if #(
  parameter int W     = 16,
  parameter int LOG2N = 3
);
  localparam int N = 1 << LOG2N;

  // Valid/ready: a frame moves on a rising edge where valid and ready are both 1.
  // The producer holds valid and data stable until that edge, and the consumer may
  // raise or drop ready at any time. One transfer carries one whole frame.
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] din_re;
  logic [N*W-1:0] din_im;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] dout_re;
  logic [N*W-1:0] dout_im;
  logic           clr_ovf;
  logic           ovf;

  modport master (
    output in_valid, din_re, din_im, out_ready, clr_ovf,
    input  in_ready, out_valid, dout_re, dout_im, ovf
  );

  modport slave (
    input  in_valid, din_re, din_im, out_ready, clr_ovf,
    output in_ready, out_valid, dout_re, dout_im, ovf
  );
endinterface

// File: rtl/fft_r2_stage.sv
// One radix-2 DIT butterfly stage over a full complex frame. Stage A holds the
// twiddle product, stage B holds the add/sub result with optional halving and saturation.
module fft_r2_stage #(
  parameter int W     = 16,
  parameter int LOG2N = 3,
  parameter int STAGE = 0,
  parameter int SCALE = 0,
  parameter int CW    = 16
) (
  input logic            clk,
  input logic            rst,
  fft_r2_stage_if.slave  bus
);

  localparam int N     = 1 << LOG2N;
  localparam int NP    = N / 2;
  localparam int SPAN  = 1 << STAGE;
  localparam int KSTEP = 16 >> (STAGE + 1);
  localparam int TSH_L = (CW >= 16) ? CW - 16 : 0;
  localparam int TSH_R = (CW >= 16) ? 0 : 16 - CW;

  localparam logic signed [W+CW:0] RND  = {{(W+3){1'b0}}, 1'b1, {(CW-3){1'b0}}};
  localparam logic signed [W+1:0]  ONE  = {{(W+1){1'b0}}, 1'b1};
  localparam logic signed [W+1:0]  MAXV = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0]  MINV = {3'b111, {(W-1){1'b0}}};

  if (STAGE >= LOG2N || LOG2N > 4 || LOG2N < 1 || STAGE < 0) begin : g_param_check
    $error("fft_r2_stage: illegal LOG2N/STAGE combination");
  end

  // 16-point twiddle table in Q1.14, rescaled to the Q1.(CW-2) coefficient format.
  function automatic logic signed [CW-1:0] tw(input int k, input bit want_im);
    int re14;
    int im14;
    int v;
    case (k)
      0:       begin re14 =  16384; im14 =      0; end
      1:       begin re14 =  15137; im14 =  -6270; end
      2:       begin re14 =  11585; im14 = -11585; end
      3:       begin re14 =   6270; im14 = -15137; end
      4:       begin re14 =      0; im14 = -16384; end
      5:       begin re14 =  -6270; im14 = -15137; end
      6:       begin re14 = -11585; im14 = -11585; end
      7:       begin re14 = -15137; im14 =  -6270; end
      default: begin re14 =      0; im14 =      0; end
    endcase
    v = want_im ? im14 : re14;
    v = (v <<< TSH_L) >>> TSH_R;
    return v[CW-1:0];
  endfunction

  // Returns {saturated, value}.
  function automatic logic [W:0] scale_sat(input logic signed [W+1:0] v);
    logic signed [W+1:0] s;
    s = (SCALE != 0) ? ((v + ONE) >>> 1) : v;
    if (s > MAXV)      return {1'b1, MAXV[W-1:0]};
    else if (s < MINV) return {1'b1, MINV[W-1:0]};
    return {1'b0, s[W-1:0]};
  endfunction

  logic                  ce;
  logic                  a_valid;
  logic                  b_valid;
  logic signed [W-1:0]   xi_re [NP];
  logic signed [W-1:0]   xi_im [NP];
  logic signed [W:0]     t_re  [NP];
  logic signed [W:0]     t_im  [NP];
  logic signed [W-1:0]   a_xr  [NP];
  logic signed [W-1:0]   a_xi  [NP];
  logic signed [W:0]     a_tr  [NP];
  logic signed [W:0]     a_ti  [NP];
  logic [N*W-1:0]        y_re;
  logic [N*W-1:0]        y_im;
  logic [NP-1:0]         sat_v;
  logic [N*W-1:0]        dout_re_q;
  logic [N*W-1:0]        dout_im_q;
  logic                  ovf_q;

  // Both stages move together; a stalled output freezes the whole pipe.
  assign ce            = !b_valid || bus.out_ready;
  assign bus.in_ready  = ce;
  assign bus.out_valid = b_valid;
  assign bus.dout_re   = dout_re_q;
  assign bus.dout_im   = dout_im_q;
  assign bus.ovf       = ovf_q;

  for (genvar p = 0; p < NP; p++) begin : g_pair
    localparam int I = ((p >> STAGE) << (STAGE + 1)) | (p & (SPAN - 1));
    localparam int J = I + SPAN;
    localparam int K = (p & (SPAN - 1)) * KSTEP;

    logic signed [W-1:0] xjr;
    logic signed [W-1:0] xji;
    logic signed [W+1:0] sr;
    logic signed [W+1:0] dr;
    logic signed [W+1:0] si;
    logic signed [W+1:0] di;
    logic [W:0]          ysr;
    logic [W:0]          ydr;
    logic [W:0]          ysi;
    logic [W:0]          ydi;

    assign xi_re[p] = bus.din_re[I*W +: W];
    assign xi_im[p] = bus.din_im[I*W +: W];
    assign xjr      = bus.din_re[J*W +: W];
    assign xji      = bus.din_im[J*W +: W];

    if (K == 0) begin : g_bypass
      assign t_re[p] = {xjr[W-1], xjr};
      assign t_im[p] = {xji[W-1], xji};
    end else begin : g_mul
      localparam logic signed [CW-1:0] CR  = tw(K, 1'b0);
      localparam logic signed [CW-1:0] CI  = tw(K, 1'b1);
      localparam logic signed [W+CW:0] CRE = {{(W+1){CR[CW-1]}}, CR};
      localparam logic signed [W+CW:0] CIE = {{(W+1){CI[CW-1]}}, CI};

      logic signed [W+CW:0] xre;
      logic signed [W+CW:0] xie;
      logic signed [W+CW:0] pr;
      logic signed [W+CW:0] pi;

      assign xre     = {{(CW+1){xjr[W-1]}}, xjr};
      assign xie     = {{(CW+1){xji[W-1]}}, xji};
      assign pr      = xre * CRE - xie * CIE + RND;
      assign pi      = xre * CIE + xie * CRE + RND;
      assign t_re[p] = pr[CW-2 +: W+1];
      assign t_im[p] = pi[CW-2 +: W+1];
    end

    assign sr  = {{2{a_xr[p][W-1]}}, a_xr[p]} + {a_tr[p][W], a_tr[p]};
    assign dr  = {{2{a_xr[p][W-1]}}, a_xr[p]} - {a_tr[p][W], a_tr[p]};
    assign si  = {{2{a_xi[p][W-1]}}, a_xi[p]} + {a_ti[p][W], a_ti[p]};
    assign di  = {{2{a_xi[p][W-1]}}, a_xi[p]} - {a_ti[p][W], a_ti[p]};
    assign ysr = scale_sat(sr);
    assign ydr = scale_sat(dr);
    assign ysi = scale_sat(si);
    assign ydi = scale_sat(di);

    assign y_re[I*W +: W] = ysr[W-1:0];
    assign y_re[J*W +: W] = ydr[W-1:0];
    assign y_im[I*W +: W] = ysi[W-1:0];
    assign y_im[J*W +: W] = ydi[W-1:0];
    assign sat_v[p]       = ysr[W] | ydr[W] | ysi[W] | ydi[W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_valid <= 1'b0;
      a_xr    <= '{default: '0};
      a_xi    <= '{default: '0};
      a_tr    <= '{default: '0};
      a_ti    <= '{default: '0};
    end else if (ce) begin
      a_valid <= bus.in_valid;
      a_xr    <= xi_re;
      a_xi    <= xi_im;
      a_tr    <= t_re;
      a_ti    <= t_im;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_valid   <= 1'b0;
      dout_re_q <= '0;
      dout_im_q <= '0;
    end else if (ce) begin
      b_valid   <= a_valid;
      dout_re_q <= y_re;
      dout_im_q <= y_im;
    end
  end

  // A saturating frame landing on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (ce && a_valid && (|sat_v)) begin
      ovf_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_r2_stage.sv
// Directed bench for fft_r2_stage: four configurations sharing one clock and reset,
// hand-computed frames, and a frame queue for the streaming and reset steps.
module tb_fft_r2_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int popped = 0;
  logic acc;
  logic [255:0] exp_q[$];

  fft_r2_stage_if #(.W(16), .LOG2N(3)) if0();
  fft_r2_stage_if #(.W(16), .LOG2N(3)) if1();
  fft_r2_stage_if #(.W(16), .LOG2N(3)) if2();
  fft_r2_stage_if #(.W(16), .LOG2N(4)) if3();

  fft_r2_stage #(.W(16), .LOG2N(3), .STAGE(0), .SCALE(0), .CW(16)) u_s0 (.clk(clk), .rst(rst), .bus(if0));
  fft_r2_stage #(.W(16), .LOG2N(3), .STAGE(0), .SCALE(1), .CW(16)) u_sc (.clk(clk), .rst(rst), .bus(if1));
  fft_r2_stage #(.W(16), .LOG2N(3), .STAGE(2), .SCALE(0), .CW(16)) u_t2 (.clk(clk), .rst(rst), .bus(if2));
  fft_r2_stage #(.W(16), .LOG2N(4), .STAGE(3), .SCALE(0), .CW(16)) u_l4 (.clk(clk), .rst(rst), .bus(if3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Stage-0 reference: adjacent pairs, twiddle is always 1.
  function automatic logic [127:0] bfly0(input logic [127:0] x);
    logic [127:0] y;
    int a;
    int b;
    for (int m = 0; m < 4; m++) begin
      a = int'($signed(x[(2*m)*16 +: 16]));
      b = int'($signed(x[(2*m+1)*16 +: 16]));
      y[(2*m)*16 +: 16]   = 16'(sat16(a + b));
      y[(2*m+1)*16 +: 16] = 16'(sat16(a - b));
    end
    return y;
  endfunction

  // One if0 cycle: log accepted frames, check emitted frames against the queue.
  task automatic cyc0();
    logic [255:0] e;
    acc = 1'b0;
    @(negedge clk);
    if (if0.in_valid && if0.in_ready) begin
      acc = 1'b1;
      exp_q.push_back({bfly0(if0.din_im), bfly0(if0.din_re)});
    end
    if (if0.out_valid && if0.out_ready) begin
      popped++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      chk("stream_frame", {if0.dout_im, if0.dout_re}, e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] fr_re;
    logic [127:0] fr_im;
    logic [255:0] f4_re;
    logic [127:0] e_re;
    logic [255:0] e4_re;
    logic [255:0] e4_im;
    logic [127:0] e_im;
    logic [255:0] snap;
    logic [127:0] bp_re [4];
    logic [127:0] bp_im [4];
    int y_t1 [8];
    int sent;

    if0.in_valid = 0; if0.din_re = '0; if0.din_im = '0; if0.out_ready = 1; if0.clr_ovf = 0;
    if1.in_valid = 0; if1.din_re = '0; if1.din_im = '0; if1.out_ready = 1; if1.clr_ovf = 0;
    if2.in_valid = 0; if2.din_re = '0; if2.din_im = '0; if2.out_ready = 1; if2.clr_ovf = 0;
    if3.in_valid = 0; if3.din_re = '0; if3.din_im = '0; if3.out_ready = 1; if3.clr_ovf = 0;

    // Reset state
    tick();
    chk("rst_out_valid", if0.out_valid, 1'b0);
    chk("rst_dout", {if0.dout_im, if0.dout_re}, '0);
    chk("rst_ovf", if0.ovf, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // Stage-0 adds: x[i] = (100*i, 0)
    y_t1 = '{100, -100, 500, -100, 900, -100, 1300, -100};
    for (int i = 0; i < 8; i++) fr_re[i*16 +: 16] = 16'(100 * i);
    for (int i = 0; i < 8; i++) e_re[i*16 +: 16] = 16'(y_t1[i]);
    if0.din_re = fr_re; if0.din_im = '0; if0.in_valid = 1;
    tick();
    if0.in_valid = 0;
    chk("add_lat1", if0.out_valid, 1'b0);
    tick();
    chk("add_valid", if0.out_valid, 1'b1);
    chk("add_re", if0.dout_re, e_re);
    chk("add_im", if0.dout_im, '0);
    chk("add_ovf", if0.ovf, 1'b0);
    tick();
    chk("add_drained", if0.out_valid, 1'b0);

    // Saturation without scaling, sticky flag and its clear
    fr_re = '0; fr_re[15:0] = 16'd30000; fr_re[31:16] = 16'd30000;
    if0.din_re = fr_re; if0.din_im = '0; if0.in_valid = 1;
    tick();
    if0.in_valid = 0;
    tick();
    chk("sat_y01", if0.dout_re[31:0], {16'd0, 16'd32767});
    chk("sat_im", if0.dout_im, '0);
    chk("sat_ovf", if0.ovf, 1'b1);
    tick();
    tick();
    chk("ovf_sticky", if0.ovf, 1'b1);
    if0.clr_ovf = 1;
    tick();
    if0.clr_ovf = 0;
    chk("ovf_clear", if0.ovf, 1'b0);
    if0.in_valid = 1;
    tick();
    if0.in_valid = 0;
    if0.clr_ovf = 1;
    tick();
    if0.clr_ovf = 0;
    chk("ovf_set_wins", if0.ovf, 1'b1);
    if0.clr_ovf = 1;
    tick();
    if0.clr_ovf = 0;
    chk("ovf_clear2", if0.ovf, 1'b0);

    // Same frame with SCALE=1: (60000+1)>>>1 = 30000, no saturation
    if1.din_re = fr_re; if1.in_valid = 1;
    tick();
    if1.in_valid = 0;
    tick();
    chk("scale_valid", if1.out_valid, 1'b1);
    chk("scale_y01", if1.dout_re[31:0], {16'd0, 16'd30000});
    chk("scale_ovf", if1.ovf, 1'b0);

    // Twiddle at STAGE=2: x[5] = (1000,0), k=2
    fr_re = '0; fr_re[5*16 +: 16] = 16'd1000;
    e_re = '0; e_re[1*16 +: 16] = 16'(707);  e_re[5*16 +: 16] = 16'(-707);
    e_im = '0; e_im[1*16 +: 16] = 16'(-707); e_im[5*16 +: 16] = 16'(707);
    if2.din_re = fr_re; if2.in_valid = 1;
    tick();
    if2.in_valid = 0;
    tick();
    chk("tw_valid", if2.out_valid, 1'b1);
    chk("tw_re", if2.dout_re, e_re);
    chk("tw_im", if2.dout_im, e_im);

    // LOG2N=4, STAGE=3: x[15] = (1024,0), pair (7,15), k=7 -> t = (-946,-392)
    f4_re = '0; f4_re[15*16 +: 16] = 16'd1024;
    e4_re = '0; e4_re[7*16 +: 16] = 16'(-946); e4_re[15*16 +: 16] = 16'(946);
    e4_im = '0; e4_im[7*16 +: 16] = 16'(-392); e4_im[15*16 +: 16] = 16'(392);
    if3.din_re = f4_re; if3.in_valid = 1;
    tick();
    if3.in_valid = 0;
    tick();
    chk("l4_valid", if3.out_valid, 1'b1);
    chk("l4_re", if3.dout_re, e4_re);
    chk("l4_im", if3.dout_im, e4_im);

    // Backpressure: four frames with a three-cycle output stall
    for (int f = 0; f < 4; f++) begin
      for (int n = 0; n < 8; n++) begin
        bp_re[f][n*16 +: 16] = 16'(int'($urandom_range(0, 4000)) - 2000);
        bp_im[f][n*16 +: 16] = 16'(int'($urandom_range(0, 4000)) - 2000);
      end
    end
    sent = 0;
    popped = 0;
    if0.out_ready = 0;
    repeat (2) begin
      if0.din_re = bp_re[sent]; if0.din_im = bp_im[sent]; if0.in_valid = 1;
      cyc0();
      if (acc) sent++;
    end
    chk("bp_prefill", sent, 2);
    snap = {if0.dout_im, if0.dout_re};
    if0.din_re = bp_re[sent]; if0.din_im = bp_im[sent];
    repeat (3) begin
      cyc0();
      chk("bp_in_ready", if0.in_ready, 1'b0);
      chk("bp_hold_valid", if0.out_valid, 1'b1);
      chk("bp_hold_dout", {if0.dout_im, if0.dout_re}, snap);
    end
    if0.out_ready = 1;
    for (int c = 0; c < 30 && (sent < 4 || exp_q.size() != 0); c++) begin
      if (sent < 4) begin
        if0.din_re = bp_re[sent]; if0.din_im = bp_im[sent]; if0.in_valid = 1;
      end else begin
        if0.in_valid = 0;
      end
      cyc0();
      if (acc) sent++;
    end
    if0.in_valid = 0;
    chk("bp_sent", sent, 4);
    chk("bp_popped", popped, 4);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Asynchronous reset with both stages holding frames
    if0.out_ready = 0;
    repeat (2) begin
      if0.din_re = bp_re[0]; if0.din_im = bp_im[0]; if0.in_valid = 1;
      cyc0();
    end
    if0.in_valid = 0;
    chk("rst_pre_valid", if0.out_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_valid", if0.out_valid, 1'b0);
    chk("rst_async_dout", {if0.dout_im, if0.dout_re}, '0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    if0.out_ready = 1;
    popped = 0;
    if0.din_re = bp_re[2]; if0.din_im = bp_im[2]; if0.in_valid = 1;
    cyc0();
    if0.in_valid = 0;
    chk("rst_accept", acc, 1'b1);
    chk("rst_lat1", if0.out_valid, 1'b0);
    cyc0();
    chk("rst_lat2", if0.out_valid, 1'b1);
    cyc0();
    chk("rst_popped", popped, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
